// File: rtl/synapse_weight_bank_pkg.sv
// Shared constants and helpers for the synaptic weight bank and its leak integrator.
package synapse_weight_bank_pkg;

  localparam int NUM_PRE     = 5;
  localparam int W_WIDTH     = 8;
  localparam int W_INIT      = 64;
  localparam int W_MIN       = 0;
  localparam int W_MAX       = 255;
  localparam int DECAY_SHIFT = 2;

  // Write-port mode select.
  localparam logic WR_OVERWRITE = 1'b0;
  localparam logic WR_DELTA     = 1'b1;

  // Saturating clamp of a signed value into [lo, hi].
  function automatic int sat_clamp(input int value, input int lo, input int hi);
    int res;
    res = value;
    if (value < lo) res = lo;
    if (value > hi) res = hi;
    return res;
  endfunction

endpackage : synapse_weight_bank_pkg

// File: rtl/synapse_weight_bank_leak_integrator.sv
// Leaky synaptic-current register: I <= sat(I - (I >> DECAY_SHIFT) + sum).
module synapse_leak_integrator #(
  parameter int W_WIDTH     = 8,
  parameter int SUM_W       = W_WIDTH + 3,
  parameter int DECAY_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SUM_W-1:0]   sum,
  output logic [W_WIDTH-1:0] current
);

  // One extra bit above the sum so that I + sum never wraps before saturation.
  localparam int EXT_W = SUM_W + 1;
  localparam logic [EXT_W-1:0] I_MAX = EXT_W'({W_WIDTH{1'b1}});

  logic [W_WIDTH-1:0] current_q, current_d;
  logic [EXT_W-1:0]   next_ext;

  // Leak, integrate the incoming weight sum, then saturate to the current width.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see earlier results;
    // every signal gets a default first so no latch is inferred.
    next_ext  = EXT_W'(current_q) - EXT_W'(current_q >> DECAY_SHIFT) + EXT_W'(sum);
    current_d = current_q;
    if (next_ext > I_MAX) begin
      current_d = I_MAX[W_WIDTH-1:0];
    end else begin
      current_d = next_ext[W_WIDTH-1:0];
    end
  end

  // Current register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking '<=' so all flops update together at the edge.
    if (!rst_n) begin
      current_q <= '0;
    end else begin
      current_q <= current_d;
    end
  end

  assign current = current_q;

endmodule : synapse_leak_integrator

// File: rtl/synapse_weight_bank.sv
// Plastic weight file with a valid/ready write port, feeding a leaky synaptic current.
module synapse_weight_bank
  import synapse_weight_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_PRE-1:0] pre_spike,
  input  logic               learn_en,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               wr_mode,
  input  logic [2:0]         wr_idx,
  input  logic [W_WIDTH-1:0] wr_data,
  input  logic [2:0]         rd_idx,
  output logic [W_WIDTH-1:0] rd_data,
  output logic [W_WIDTH-1:0] current_out,
  output logic [3:0]         spike_cnt,
  output logic               idx_err
);

  localparam int SUM_W = W_WIDTH + 3;
  localparam int DLT_W = W_WIDTH + 2;

  logic [W_WIDTH-1:0] weight_q [NUM_PRE];
  logic [W_WIDTH-1:0] weight_d [NUM_PRE];
  logic               idx_err_q, idx_err_d;
  logic [W_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [3:0]         spike_cnt_q, spike_cnt_d;
  logic [SUM_W-1:0]   spike_sum;
  logic               wr_fire;
  logic               wr_hit;
  logic signed [DLT_W-1:0] delta_sum;

  // The learner may write whenever learning is enabled; no backpressure otherwise.
  assign wr_ready = learn_en;
  assign wr_fire  = wr_valid && wr_ready;

  // Weight write decode: overwrite or clamped signed delta; bad index sets the sticky error.
  always_comb begin
    weight_d  = weight_q;
    idx_err_d = idx_err_q;
    wr_hit    = 1'b0;
    delta_sum = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (wr_fire && (wr_idx == 3'(i))) begin
        wr_hit    = 1'b1;
        delta_sum = $signed({2'b00, weight_q[i]})
                  + $signed({{2{wr_data[W_WIDTH-1]}}, wr_data});
        if (wr_mode == WR_OVERWRITE) begin
          weight_d[i] = wr_data;
        end else begin
          weight_d[i] = W_WIDTH'(sat_clamp(int'(delta_sum), W_MIN, W_MAX));
        end
      end
    end
    if (wr_fire && !wr_hit) begin
      idx_err_d = 1'b1;
    end
  end

  // Weight sum of firing inputs (old weights, so a same-cycle write lands next cycle),
  // spike popcount and the debug read mux.
  always_comb begin
    spike_sum   = '0;
    spike_cnt_d = '0;
    rd_data_d   = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (pre_spike[i]) begin
        spike_sum   = spike_sum + SUM_W'(weight_q[i]);
        spike_cnt_d = spike_cnt_d + 4'd1;
      end
      if (rd_idx == 3'(i)) begin
        rd_data_d = weight_q[i];
      end
    end
  end

  // Weight file and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the weight file is a handful of flops that must start at W_INIT,
      // so it is reset like any other register rather than treated as a RAM.
      for (int i = 0; i < NUM_PRE; i++) begin
        weight_q[i] <= W_WIDTH'(W_INIT);
      end
      idx_err_q   <= 1'b0;
      rd_data_q   <= '0;
      spike_cnt_q <= '0;
    end else begin
      weight_q    <= weight_d;
      idx_err_q   <= idx_err_d;
      rd_data_q   <= rd_data_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  synapse_leak_integrator #(
    .W_WIDTH     (W_WIDTH),
    .SUM_W       (SUM_W),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_leak (
    .clk     (clk),
    .rst_n   (rst_n),
    .sum     (spike_sum),
    .current (current_out)
  );

  assign rd_data   = rd_data_q;
  assign spike_cnt = spike_cnt_q;
  assign idx_err   = idx_err_q;

endmodule : synapse_weight_bank

// File: tb/tb_synapse_weight_bank.sv
// Directed bench for synapse_weight_bank with hand-computed expectations.
module tb_synapse_weight_bank;
  import synapse_weight_bank_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [NUM_PRE-1:0] pre_spike;
  logic               learn_en;
  logic               wr_valid;
  logic               wr_ready;
  logic               wr_mode;
  logic [2:0]         wr_idx;
  logic [W_WIDTH-1:0] wr_data;
  logic [2:0]         rd_idx;
  logic [W_WIDTH-1:0] rd_data;
  logic [W_WIDTH-1:0] current_out;
  logic [3:0]         spike_cnt;
  logic               idx_err;

  int n_vec = 0;
  int n_err = 0;

  synapse_weight_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_spike   (pre_spike),
    .learn_en    (learn_en),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_mode     (wr_mode),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .current_out (current_out),
    .spike_cnt   (spike_cnt),
    .idx_err     (idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // Single-cycle accepted write (learn_en held high by the caller).
  task automatic write_weight(input logic mode, input logic [2:0] idx, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_mode  = mode;
    wr_idx   = idx;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_weight(input logic [2:0] idx, input string tag, input int exp);
    rd_idx = idx;
    tick();
    check(tag, int'(rd_data), exp);
  endtask

  // Expected decay trace for a single weight-64 spike from zero current.
  int decay_tbl[5] = '{64, 48, 36, 27, 21};

  initial begin
    rst_n     = 1'b0;
    pre_spike = '0;
    learn_en  = 1'b0;
    wr_valid  = 1'b0;
    wr_mode   = WR_OVERWRITE;
    wr_idx    = '0;
    wr_data   = '0;
    rd_idx    = '0;
    #12;
    check("rst_current", int'(current_out), 0);
    check("rst_spike_cnt", int'(spike_cnt), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_idx_err", int'(idx_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single spike on input 0 and its geometric decay.
    pre_spike = 5'b00001;
    tick();
    pre_spike = '0;
    check("single_cnt1", int'(spike_cnt), 1);
    check("decay_0", int'(current_out), decay_tbl[0]);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("decay_%0d", k), int'(current_out), decay_tbl[k]);
      if (k == 1) check("single_cnt0", int'(spike_cnt), 0);
    end
    // 21 -> 16 12 9 7 6 5 4 3, then held.
    for (int k = 0; k < 12; k++) tick();
    check("decay_residual", int'(current_out), 3);

    // All five inputs for two cycles: 320 saturates to 255.
    pre_spike = 5'b11111;
    tick();
    check("sat_cycle0", int'(current_out), 255);
    check("sat_cnt", int'(spike_cnt), 5);
    tick();
    pre_spike = '0;
    check("sat_cycle1", int'(current_out), 255);

    // Delta writes at index 2 with clamping; read shows the pre-write value first.
    learn_en = 1'b1;
    rd_idx   = 3'd2;
    write_weight(WR_DELTA, 3'd2, 8'h9C);
    check("rd_prewrite", int'(rd_data), 64);
    read_weight(3'd2, "delta_clamp_min", 0);
    write_weight(WR_OVERWRITE, 3'd2, 8'd200);
    read_weight(3'd2, "overwrite_200", 200);
    write_weight(WR_DELTA, 3'd2, 8'd100);
    read_weight(3'd2, "delta_clamp_max", 255);

    // Collision: write idx 0 = 10 together with a spike on input 0, from current 0.
    @(negedge clk);
    reset_pulse();
    learn_en  = 1'b1;
    pre_spike = 5'b00001;
    write_weight(WR_OVERWRITE, 3'd0, 8'd10);
    pre_spike = '0;
    check("collision_old_weight", int'(current_out), 64);
    for (int k = 0; k < 14; k++) tick();
    check("collision_residual", int'(current_out), 3);
    pre_spike = 5'b00001;
    tick();
    pre_spike = '0;
    check("collision_new_weight", int'(current_out), 13);
    read_weight(3'd0, "rd_w0_new", 10);

    // Out-of-range write index: handshake completes, no weight change, sticky error.
    @(negedge clk);
    reset_pulse();
    learn_en = 1'b1;
    wr_valid = 1'b1;
    wr_idx   = 3'd5;
    #1;
    check("bad_idx_ready", int'(wr_ready), 1);
    write_weight(WR_OVERWRITE, 3'd5, 8'd7);
    check("idx_err_set", int'(idx_err), 1);
    for (int i = 0; i < NUM_PRE; i++) begin
      read_weight(3'(i), $sformatf("bad_idx_w%0d", i), 64);
    end
    read_weight(3'd5, "rd_oob_zero", 0);
    check("idx_err_sticky", int'(idx_err), 1);

    // learn_en low: write dropped, ready low.
    learn_en = 1'b0;
    wr_valid = 1'b1;
    wr_idx   = 3'd1;
    wr_data  = 8'd0;
    #1;
    check("no_learn_ready", int'(wr_ready), 0);
    tick();
    wr_valid = 1'b0;
    read_weight(3'd1, "no_learn_w1", 64);

    // Spike, then async reset in mid-decay.
    pre_spike = 5'b00011;
    tick();
    pre_spike = '0;
    check("pre_reset_current", int'(current_out), 128);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_current", int'(current_out), 0);
    check("async_rst_idx_err", int'(idx_err), 0);
    check("async_rst_cnt", int'(spike_cnt), 0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_synapse_weight_bank
